// File: rtl/p20_parallax_scroll_if.sv
// Controller/renderer bundle for the parallax scroll-timing generator.
// The master side drives halt and speed/step settings; the slave side returns positions and timing.
interface p20_parallax_scroll_if #(
    parameter int unsigned LAYERS = 3,
    parameter int unsigned POS_W  = 11
);
    logic                      halt;
    logic [7:0]                speed_change;
    logic [7:0]                move_amt;
    logic [LAYERS*POS_W-1:0]   pos;
    logic [23:0]               speed;
    logic                      tick;
    logic [15:0]               distance;

    modport master (
        output halt, speed_change, move_amt,
        input  pos, speed, tick, distance
    );

    modport slave (
        input  halt, speed_change, move_amt,
        output pos, speed, tick, distance
    );
endinterface

// File: rtl/p20_parallax_scroll.sv
// Multi-layer parallax scroll engine: shared accelerating tick timer, per-layer wrapped positions, distance counter.
// Macro P20_SCROLL_ACCEL_EN enables the tick-period speed-up; when undefined the period stays at INITIAL_TICK.
module p20_parallax_scroll #(
    parameter int unsigned LAYERS       = 3,
    parameter int unsigned POS_W        = 11,
    parameter int unsigned CTR_W        = 18,
    parameter int unsigned INITIAL_TICK = 250000,
    parameter int unsigned MIN_TICK     = 50000,
    parameter int unsigned WRAP         = 1280
) (
    input  logic clk,
    input  logic sys_rst,
    input  logic game_rst,
    p20_parallax_scroll_if.slave bus
);
    localparam int unsigned SUM_W  = POS_W + 1;
    localparam int unsigned DIST_W = 16;

    logic                rst_c;
    logic                tick_evt_c;
    logic [CTR_W-1:0]    cnt_q, cnt_d;
    logic [CTR_W-1:0]    period_c;
    logic                tick_q, tick_d;
    logic [DIST_W-1:0]   dist_q, dist_d;
    logic [POS_W-1:0]    pos_q [LAYERS];
    logic [POS_W-1:0]    pos_d [LAYERS];

    assign rst_c      = sys_rst | game_rst;
    assign tick_evt_c = !bus.halt && (cnt_q >= period_c);

`ifdef P20_SCROLL_ACCEL_EN
    logic [CTR_W-1:0] period_q, period_d;
    logic [CTR_W:0]   period_diff_c;

    assign period_c      = period_q;
    assign period_diff_c = {1'b0, period_q} - (CTR_W+1)'(bus.speed_change);

    // Borrow out of the wide subtraction means the result went negative.
    always_comb begin
        period_d = period_q;
        if (tick_evt_c) begin
            if (period_diff_c[CTR_W] || (period_diff_c < (CTR_W+1)'(MIN_TICK)))
                period_d = CTR_W'(MIN_TICK);
            else
                period_d = period_diff_c[CTR_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_c) period_q <= CTR_W'(INITIAL_TICK);
        else       period_q <= period_d;
    end
`else
    logic [7:0] unused_speed_change;

    assign period_c            = CTR_W'(INITIAL_TICK);
    assign unused_speed_change = bus.speed_change;
`endif

    // Counter, tick pulse and saturating distance.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        dist_d = dist_q;
        if (!bus.halt) begin
            if (tick_evt_c) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                if (dist_q != {DIST_W{1'b1}})
                    dist_d = dist_q + DIST_W'(1);
            end else begin
                cnt_d = cnt_q + CTR_W'(1);
            end
        end
    end

    // Each layer steps by move_amt >> l; one subtraction wraps because steps never exceed WRAP.
    for (genvar l = 0; l < LAYERS; l++) begin : g_layer
        logic [SUM_W-1:0] step_c;
        logic [SUM_W-1:0] sum_c;

        if (l < 8) begin : g_step
            assign step_c = SUM_W'(bus.move_amt >> l);
        end else begin : g_nostep
            assign step_c = '0;
        end

        assign sum_c = {1'b0, pos_q[l]} + step_c;

        always_comb begin
            pos_d[l] = pos_q[l];
            if (tick_evt_c) begin
                if (sum_c >= SUM_W'(WRAP))
                    pos_d[l] = POS_W'(sum_c - SUM_W'(WRAP));
                else
                    pos_d[l] = sum_c[POS_W-1:0];
            end
        end

        always_ff @(posedge clk) begin
            if (rst_c) pos_q[l] <= '0;
            else       pos_q[l] <= pos_d[l];
        end

        assign bus.pos[l*POS_W +: POS_W] = pos_q[l];
    end

    always_ff @(posedge clk) begin
        if (rst_c) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            dist_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            dist_q <= dist_d;
        end
    end

    assign bus.tick     = tick_q;
    assign bus.distance = dist_q;
    assign bus.speed    = 24'(period_c);
endmodule

// File: tb/tb_p20_parallax_scroll.sv
// Directed bench for p20_parallax_scroll: tick spacing, speed-up, layer wrap, halt, game reset, distance saturation.
// Expectations follow P20_SCROLL_ACCEL_EN when it is defined for the build.
module tb_p20_parallax_scroll;
    logic clk = 1'b0;
    logic sys_rst;
    logic game_rst;
    logic sat_rst;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    p20_parallax_scroll_if #(.LAYERS(3), .POS_W(11)) if_main ();
    p20_parallax_scroll_if #(.LAYERS(3), .POS_W(11)) if_sat ();

    p20_parallax_scroll #(
        .LAYERS(3), .POS_W(11), .CTR_W(18),
        .INITIAL_TICK(4), .MIN_TICK(2), .WRAP(20)
    ) u_dut (
        .clk(clk), .sys_rst(sys_rst), .game_rst(game_rst), .bus(if_main)
    );

    p20_parallax_scroll #(
        .LAYERS(3), .POS_W(11), .CTR_W(18),
        .INITIAL_TICK(0), .MIN_TICK(0), .WRAP(20)
    ) u_sat (
        .clk(clk), .sys_rst(sat_rst), .game_rst(1'b0), .bus(if_sat)
    );

`ifdef P20_SCROLL_ACCEL_EN
    int gap_exp [5] = '{5, 4, 3, 3, 3};
    int spd_pre [5] = '{4, 3, 2, 2, 2};
    int spd_post[5] = '{3, 2, 2, 2, 2};
    localparam int SPD_LATE = 2;
    localparam int GAP_LATE = 3;
`else
    int gap_exp [5] = '{5, 5, 5, 5, 5};
    int spd_pre [5] = '{4, 4, 4, 4, 4};
    int spd_post[5] = '{4, 4, 4, 4, 4};
    localparam int SPD_LATE = 4;
    localparam int GAP_LATE = 5;
`endif
    int l0_exp[5] = '{8, 16, 4, 12, 0};
    int l1_exp[5] = '{4, 8, 12, 16, 0};
    int l2_exp[5] = '{2, 4, 6, 8, 10};

    function automatic logic [31:0] lay(input logic [32:0] p, input int l);
        return 32'(p[l*11 +: 11]);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // Counts sampled edges until tick is seen or the budget runs out.
    task automatic wait_tick(input int budget, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!if_main.tick && n < budget);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int hold_bad;
        int sat_bad;

        sys_rst  = 1'b1;
        game_rst = 1'b0;
        sat_rst  = 1'b1;
        if_main.halt = 1'b0; if_main.speed_change = 8'd1; if_main.move_amt = 8'd8;
        if_sat.halt  = 1'b0; if_sat.speed_change  = 8'd1; if_sat.move_amt  = 8'd8;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_pos",  32'(if_main.pos), 0);
        check_eq("rst_spd",  if_main.speed, 4);
        check_eq("rst_dist", if_main.distance, 0);
        check_eq("rst_tick", if_main.tick, 0);
        sys_rst = 1'b0;

        for (int k = 0; k < 5; k++) begin
            check_eq($sformatf("spd_pre%0d", k + 1), if_main.speed, spd_pre[k]);
            wait_tick(20, n);
            check_eq($sformatf("gap%0d", k + 1), n, gap_exp[k]);
            check_eq($sformatf("spd_post%0d", k + 1), if_main.speed, spd_post[k]);
            check_eq($sformatf("l0_t%0d", k + 1), lay(if_main.pos, 0), l0_exp[k]);
            check_eq($sformatf("l1_t%0d", k + 1), lay(if_main.pos, 1), l1_exp[k]);
            check_eq($sformatf("l2_t%0d", k + 1), lay(if_main.pos, 2), l2_exp[k]);
            check_eq($sformatf("dist_t%0d", k + 1), if_main.distance, k + 1);
        end

        // Halt for 7 edges one cycle into the period.
        @(posedge clk);
        #1;
        if_main.halt = 1'b1;
        hold_bad = 0;
        repeat (7) begin
            @(posedge clk);
            #1;
            if (if_main.tick !== 1'b0) hold_bad++;
            if (lay(if_main.pos, 0) != 0 || lay(if_main.pos, 1) != 0 || lay(if_main.pos, 2) != 10) hold_bad++;
            if (if_main.distance != 16'd5 || if_main.speed != 24'(SPD_LATE)) hold_bad++;
        end
        if_main.halt = 1'b0;
        check_eq("halt_frozen", hold_bad, 0);
        wait_tick(30, n);
        check_eq("halt_gap", n + 8, GAP_LATE + 7);
        check_eq("halt_l0", lay(if_main.pos, 0), 8);
        check_eq("halt_l1", lay(if_main.pos, 1), 4);
        check_eq("halt_l2", lay(if_main.pos, 2), 12);
        check_eq("halt_dist", if_main.distance, 6);

        // game_rst lands on the edge where the next tick is due.
        repeat (GAP_LATE - 1) @(posedge clk);
        #1;
        check_eq("pre_grst_tick", if_main.tick, 0);
        game_rst = 1'b1;
        @(posedge clk);
        #1;
        game_rst = 1'b0;
        check_eq("grst_pos",  32'(if_main.pos), 0);
        check_eq("grst_spd",  if_main.speed, 4);
        check_eq("grst_dist", if_main.distance, 0);
        check_eq("grst_tick", if_main.tick, 0);
        wait_tick(20, n);
        check_eq("grst_gap", n, 5);
        check_eq("grst_dist1", if_main.distance, 1);

        // Period-0 instance ticks every cycle; distance must saturate.
        sat_rst = 1'b0;
        sat_bad = 0;
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk);
            #1;
            if (if_sat.tick !== 1'b0 && if_sat.tick !== 1'b1) sat_bad++;
            if (if_sat.tick !== 1'b1) sat_bad++;
            if (lay(if_sat.pos, 0) >= 20 || lay(if_sat.pos, 1) >= 20 || lay(if_sat.pos, 2) >= 20) sat_bad++;
        end
        check_eq("sat_run",  sat_bad, 0);
        check_eq("sat_dist", if_sat.distance, 32'hFFFF);
        check_eq("sat_spd",  if_sat.speed, 0);
        check_eq("sat_l0",   lay(if_sat.pos, 0), 0);
        check_eq("sat_l2",   lay(if_sat.pos, 2), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
